// File: rtl/run_event_logger_pkg.sv
// Default geometry shared by the run event logger and its FIFO.
package run_event_logger_pkg;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/run_event_fifo.sv
// Synchronous timestamp FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module run_event_fifo
    import run_event_logger_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        level_d = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/run_event_logger.sv
// Timestamps each rising edge of the run-detected level, buffers the
// stamps for a valid/ready consumer, and keeps count/overflow status.
module run_event_logger
    import run_event_logger_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clr,
    output logic             ev_valid,
    output logic [TS_W-1:0]  ev_ts,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] ev_count,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  ts_d;
    logic             det_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             rise;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;

    assign rise     = det & ~det_q;
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;
    // A pop in the same cycle makes room, so only full-without-pop drops.
    assign drop     = rise & full & ~pop;

    always_comb begin
        ts_d  = ts_q + TS_W'(1);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = rise ? CNT_W'(1) : '0;
        end else if (rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ovf_d = drop | (ovf_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q  <= '0;
            det_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            det_q <= det;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    run_event_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rise),
        .pop   (pop),
        .wdata (ts_q),
        .rdata (ev_ts),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign ev_count = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_run_event_logger.sv
// Directed bench for run_event_logger with a timestamp scoreboard.
module tb_run_event_logger;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        det = 1'b0;
    logic        clr = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_ts;
    logic [7:0]  ev_count;
    logic        overflow;
    logic [2:0]  fifo_level;

    logic        det_s = 1'b0;
    logic        clr_s = 1'b0;
    logic        rdy_s = 1'b0;
    logic        s_valid;
    logic [3:0]  s_ts;
    logic [7:0]  s_cnt;
    logic        s_ovf;
    logic [2:0]  s_lvl;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q[$];
    int          cnt_m = 0;
    bit          ovf_m = 1'b0;
    bit          det_prev = 1'b0;
    int          tb_ts = 0;

    always #5 clk = ~clk;

    run_event_logger dut (
        .clk        (clk),
        .rst        (rst),
        .det        (det),
        .clr        (clr),
        .ev_valid   (ev_valid),
        .ev_ts      (ev_ts),
        .ev_ready   (ev_ready),
        .ev_count   (ev_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    run_event_logger #(.TS_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .det        (det_s),
        .clr        (clr_s),
        .ev_valid   (s_valid),
        .ev_ts      (s_ts),
        .ev_ready   (rdy_s),
        .ev_count   (s_cnt),
        .overflow   (s_ovf),
        .fifo_level (s_lvl)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit pop;
        bit rise;
        if (rst) begin
            pop = (sb_q.size() > 0) && ev_ready;
            if (pop) begin
                chk("pop_ts", {16'd0, ev_ts}, {16'd0, sb_q[0]});
                void'(sb_q.pop_front());
            end
            rise = det && !det_prev;
            if (clr) begin
                cnt_m = 0;
                ovf_m = 1'b0;
            end
            if (rise) begin
                if (cnt_m < 255) cnt_m++;
                if (sb_q.size() < DEPTH) sb_q.push_back(tb_ts[15:0]);
                else ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        if (rst) begin
            tb_ts++;
            det_prev = det;
        end else begin
            det_prev = 1'b0;
        end
        #1;
        chk("valid", {31'd0, ev_valid}, {31'd0, sb_q.size() > 0});
        chk("level", {29'd0, fifo_level}, sb_q.size());
        chk("count", {24'd0, ev_count}, cnt_m);
        chk("ovf", {31'd0, overflow}, {31'd0, ovf_m});
        if (sb_q.size() > 0) chk("head_ts", {16'd0, ev_ts}, {16'd0, sb_q[0]});
        else chk("empty_ts", {16'd0, ev_ts}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, ev_valid}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_count", {24'd0, ev_count}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        sb_q.delete();
        cnt_m = 0;
        ovf_m = 1'b0;
        det_prev = 1'b0;
        repeat (3) begin
            det = ~det;
            step();
        end
        det = 1'b0;
        clr = 1'b0;
        ev_ready = 1'b0;
        rst = 1'b1;
        tb_ts = 0;
    endtask

    task automatic run_until(int t);
        int g;
        g = 0;
        while (tb_ts < t && g < 5000) begin
            step();
            g++;
        end
        chk("run_until", tb_ts, t);
    endtask

    task automatic pulse();
        det = 1'b1;
        step();
        det = 1'b0;
    endtask

    initial begin
        int exp3[4];
        int exp4[4];
        exp3 = '{10, 13, 16, 19};
        exp4 = '{4, 6, 8, 10};

        do_reset();
        run_until(5);
        chk("pre_rise_valid", {31'd0, ev_valid}, 0);
        det = 1'b1;
        step();
        chk("first_valid", {31'd0, ev_valid}, 1);
        chk("first_ts", {16'd0, ev_ts}, 5);
        chk("first_cnt", {24'd0, ev_count}, 1);
        chk("first_lvl", {29'd0, fifo_level}, 1);
        repeat (9) step();
        det = 1'b0;
        step();
        chk("held_cnt", {24'd0, ev_count}, 1);
        chk("held_lvl", {29'd0, fifo_level}, 1);

        do_reset();
        foreach (exp3[i]) begin
            run_until(exp3[i]);
            pulse();
        end
        run_until(22);
        pulse();
        step();
        chk("fill_lvl", {29'd0, fifo_level}, 4);
        chk("fill_ovf", {31'd0, overflow}, 1);
        chk("fill_cnt", {24'd0, ev_count}, 5);
        ev_ready = 1'b1;
        foreach (exp3[i]) begin
            chk("drain_ts", {16'd0, ev_ts}, exp3[i]);
            step();
        end
        chk("drained_valid", {31'd0, ev_valid}, 0);
        repeat (2) step();
        chk("idle_lvl", {29'd0, fifo_level}, 0);

        do_reset();
        for (int t = 2; t <= 8; t += 2) begin
            run_until(t);
            pulse();
        end
        run_until(10);
        chk("full_lvl", {29'd0, fifo_level}, 4);
        det = 1'b1;
        ev_ready = 1'b1;
        step();
        det = 1'b0;
        ev_ready = 1'b0;
        chk("swap_lvl", {29'd0, fifo_level}, 4);
        chk("swap_ovf", {31'd0, overflow}, 0);
        ev_ready = 1'b1;
        foreach (exp4[i]) begin
            chk("swap_ts", {16'd0, ev_ts}, exp4[i]);
            step();
        end
        chk("swap_empty", {31'd0, ev_valid}, 0);

        do_reset();
        ev_ready = 1'b1;
        repeat (300) begin
            det = 1'b1;
            step();
            det = 1'b0;
            step();
        end
        chk("sat_cnt", {24'd0, ev_count}, 255);
        chk("sat_ovf", {31'd0, overflow}, 0);
        clr = 1'b1;
        det = 1'b1;
        step();
        clr = 1'b0;
        det = 1'b0;
        chk("clr_rise_cnt", {24'd0, ev_count}, 1);
        chk("clr_rise_ovf", {31'd0, overflow}, 0);
        repeat (2) step();
        ev_ready = 1'b0;
        repeat (4) begin
            pulse();
            step();
        end
        chk("refill_lvl", {29'd0, fifo_level}, 4);
        clr = 1'b1;
        det = 1'b1;
        step();
        clr = 1'b0;
        det = 1'b0;
        chk("clr_drop_ovf", {31'd0, overflow}, 1);
        chk("clr_drop_cnt", {24'd0, ev_count}, 1);
        step();

        do_reset();
        run_until(17);
        det_s = 1'b1;
        step();
        det_s = 1'b0;
        chk("wrap_valid", {31'd0, s_valid}, 1);
        chk("wrap_ts", {28'd0, s_ts}, 17 % 16);
        chk("wrap_cnt", {24'd0, s_cnt}, 1);
        chk("wrap_lvl", {29'd0, s_lvl}, 1);
        chk("wrap_ovf", {31'd0, s_ovf}, 0);
        repeat (3) begin
            pulse();
            step();
        end
        chk("pre_rst_lvl", {29'd0, fifo_level}, 3);
        do_reset();
        chk("post_rst_svalid", {31'd0, s_valid}, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
